// File: rtl/axi_llc_evict_tracker.sv
// rtl/axi_llc_evict_tracker.sv - LLC eviction writeback tracker: AW/W/B issue with in-order retire
// Optional macro AXI_LLC_EVICT_PERF_EN adds evict_cnt_o / err_cnt_o performance counters.
module axi_llc_evict_tracker #(
    parameter int AddrWidth   = 64,
    parameter int IdWidth     = 4,
    parameter int AwId        = 0,
    parameter int DataWidth   = 64,
    parameter int DescWidth   = 128,
    parameter int MaxInflight = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [DescWidth-1:0]               desc_i,
    input  logic                               desc_evict_i,
    input  logic                               desc_flush_i,
    input  logic [AddrWidth-1:0]               desc_addr_i,
    input  logic [7:0]                         desc_len_i,
    input  logic                               desc_valid_i,
    output logic                               desc_ready_o,
    output logic [DescWidth-1:0]               desc_o,
    output logic                               desc_err_o,
    output logic                               desc_valid_o,
    input  logic                               desc_ready_i,
    output logic                               rd_req_valid_o,
    input  logic                               rd_req_ready_i,
    output logic [7:0]                         rd_req_beat_o,
    input  logic [DataWidth-1:0]               rd_data_i,
    input  logic                               rd_data_valid_i,
    output logic                               rd_data_ready_o,
    output logic [AddrWidth-1:0]               aw_addr_o,
    output logic [7:0]                         aw_len_o,
    output logic [IdWidth-1:0]                 aw_id_o,
    output logic                               aw_valid_o,
    input  logic                               aw_ready_i,
    output logic [DataWidth-1:0]               w_data_o,
    output logic [DataWidth/8-1:0]             w_strb_o,
    output logic                               w_last_o,
    output logic                               w_valid_o,
    input  logic                               w_ready_i,
    input  logic [1:0]                         b_resp_i,
    input  logic                               b_valid_i,
    output logic                               b_ready_o,
    output logic                               flush_desc_recv_o,
`ifdef AXI_LLC_EVICT_PERF_EN
    output logic [31:0]                        evict_cnt_o,
    output logic [31:0]                        err_cnt_o,
`endif
    output logic [$clog2(MaxInflight+1)-1:0]   inflight_o
);

    localparam int PtrWidth = (MaxInflight > 1) ? $clog2(MaxInflight) : 1;
    localparam int CntWidth = $clog2(MaxInflight + 1);
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxInflight);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxInflight - 1);

    logic [DescWidth-1:0] ent_payload [MaxInflight];
    logic [AddrWidth-1:0] ent_addr    [MaxInflight];
    logic [7:0]           ent_len     [MaxInflight];
    logic [MaxInflight-1:0] ent_evict, ent_flush, ent_aw_done, ent_w_done, ent_b_done, ent_err;

    logic [PtrWidth-1:0] alloc_ptr, ret_ptr;
    logic [CntWidth-1:0] count;
    logic                ready_en;

    logic                w_active;
    logic [PtrWidth-1:0] w_idx;
    logic [8:0]          req_cnt;
    logic [7:0]          beat_cnt;

    logic                aw_found, w_found, b_found;
    logic [PtrWidth-1:0] aw_idx, w_cand, b_idx;
    logic                head_done, accept, retire, aw_fire, b_fire, w_fire;
    logic                resp_unused;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    // Scan live entries from oldest to youngest; first hit is the oldest candidate per stage.
    always_comb begin
        int pos;
        logic [PtrWidth-1:0] idx;
        aw_found = 1'b0;
        w_found  = 1'b0;
        b_found  = 1'b0;
        aw_idx   = '0;
        w_cand   = '0;
        b_idx    = '0;
        pos      = 0;
        idx      = '0;
        for (int i = 0; i < MaxInflight; i++) begin
            pos = (int'(ret_ptr) + i) % MaxInflight;
            idx = PtrWidth'(pos);
            if (i < int'(count) && ent_evict[idx]) begin
                if (!aw_found && !ent_aw_done[idx]) begin
                    aw_found = 1'b1;
                    aw_idx   = idx;
                end
                if (!w_found && !ent_w_done[idx]) begin
                    w_found = 1'b1;
                    w_cand  = idx;
                end
                if (!b_found && !ent_b_done[idx]) begin
                    b_found = 1'b1;
                    b_idx   = idx;
                end
            end
        end
    end

    assign resp_unused       = b_resp_i[0];
    assign desc_ready_o      = ready_en && (count < MaxCnt);
    assign accept            = desc_valid_i && desc_ready_o;
    assign head_done         = (count != '0) && ent_b_done[ret_ptr];
    assign desc_valid_o      = head_done && !ent_flush[ret_ptr];
    assign flush_desc_recv_o = head_done && ent_flush[ret_ptr];
    assign retire            = flush_desc_recv_o || (desc_valid_o && desc_ready_i);
    assign desc_o            = desc_valid_o ? ent_payload[ret_ptr] : '0;
    assign desc_err_o        = desc_valid_o && ent_err[ret_ptr];
    assign inflight_o        = count;

    assign aw_valid_o = aw_found;
    assign aw_addr_o  = aw_found ? ent_addr[aw_idx] : '0;
    assign aw_len_o   = aw_found ? ent_len[aw_idx] : '0;
    assign aw_id_o    = aw_found ? IdWidth'(AwId) : '0;
    assign aw_fire    = aw_valid_o && aw_ready_i;

    assign rd_req_valid_o  = w_active && (req_cnt <= {1'b0, ent_len[w_idx]});
    assign rd_req_beat_o   = req_cnt[7:0];
    assign rd_data_ready_o = w_active && w_ready_i;
    assign w_valid_o       = w_active && rd_data_valid_i;
    assign w_data_o        = w_active ? rd_data_i : '0;
    assign w_strb_o        = {(DataWidth/8){w_active}};
    assign w_last_o        = w_active && (beat_cnt == ent_len[w_idx]);
    assign w_fire          = w_valid_o && w_ready_i;

    assign b_ready_o = b_found && ent_w_done[b_idx];
    assign b_fire    = b_ready_o && b_valid_i;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            ent_payload[alloc_ptr] <= desc_i;
            ent_addr[alloc_ptr]    <= desc_addr_i;
            ent_len[alloc_ptr]     <= desc_len_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alloc_ptr   <= '0;
            ret_ptr     <= '0;
            count       <= '0;
            ready_en    <= 1'b0;
            ent_evict   <= '0;
            ent_flush   <= '0;
            ent_aw_done <= '0;
            ent_w_done  <= '0;
            ent_b_done  <= '0;
            ent_err     <= '0;
            w_active    <= 1'b0;
            w_idx       <= '0;
            req_cnt     <= '0;
            beat_cnt    <= '0;
        end else begin
            ready_en <= 1'b1;
            // Non-evicting descriptors are born complete so they only wait for in-order retire.
            if (accept) begin
                alloc_ptr              <= next_ptr(alloc_ptr);
                ent_evict[alloc_ptr]   <= desc_evict_i;
                ent_flush[alloc_ptr]   <= desc_flush_i;
                ent_aw_done[alloc_ptr] <= ~desc_evict_i;
                ent_w_done[alloc_ptr]  <= ~desc_evict_i;
                ent_b_done[alloc_ptr]  <= ~desc_evict_i;
                ent_err[alloc_ptr]     <= 1'b0;
            end
            if (aw_fire) begin
                ent_aw_done[aw_idx] <= 1'b1;
            end
            if (b_fire) begin
                ent_b_done[b_idx] <= 1'b1;
                ent_err[b_idx]    <= b_resp_i[1];
            end
            if (retire) begin
                ret_ptr <= next_ptr(ret_ptr);
            end
            if (accept && !retire) begin
                count <= count + CntWidth'(1);
            end else if (!accept && retire) begin
                count <= count - CntWidth'(1);
            end

            if (!w_active) begin
                if (w_found && ent_aw_done[w_cand]) begin
                    w_active <= 1'b1;
                    w_idx    <= w_cand;
                    req_cnt  <= '0;
                    beat_cnt <= '0;
                end
            end else begin
                if (rd_req_valid_o && rd_req_ready_i) begin
                    req_cnt <= req_cnt + 9'd1;
                end
                if (w_fire) begin
                    beat_cnt <= beat_cnt + 8'd1;
                    if (w_last_o) begin
                        ent_w_done[w_idx] <= 1'b1;
                        w_active          <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef AXI_LLC_EVICT_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evict_cnt_o <= '0;
            err_cnt_o   <= '0;
        end else begin
            if (aw_fire && (evict_cnt_o != 32'hFFFF_FFFF)) begin
                evict_cnt_o <= evict_cnt_o + 32'd1;
            end
            if (b_fire && b_resp_i[1] && (err_cnt_o != 32'hFFFF_FFFF)) begin
                err_cnt_o <= err_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_llc_evict_tracker.sv
// tb/tb_axi_llc_evict_tracker.sv - directed self-checking bench for axi_llc_evict_tracker
// Optional macro AXI_LLC_EVICT_PERF_EN enables the performance counter checks.
module tb_axi_llc_evict_tracker;

    logic         clk;
    logic         rst_i;
    logic [127:0] desc_i;
    logic         desc_evict_i, desc_flush_i;
    logic [63:0]  desc_addr_i;
    logic [7:0]   desc_len_i;
    logic         desc_valid_i, desc_ready_o;
    logic [127:0] desc_o;
    logic         desc_err_o, desc_valid_o, desc_ready_i;
    logic         rd_req_valid_o, rd_req_ready_i;
    logic [7:0]   rd_req_beat_o;
    logic [63:0]  rd_data_i;
    logic         rd_data_valid_i, rd_data_ready_o;
    logic [63:0]  aw_addr_o;
    logic [7:0]   aw_len_o;
    logic [3:0]   aw_id_o;
    logic         aw_valid_o, aw_ready_i;
    logic [63:0]  w_data_o;
    logic [7:0]   w_strb_o;
    logic         w_last_o, w_valid_o, w_ready_i;
    logic [1:0]   b_resp_i;
    logic         b_valid_i, b_ready_o;
    logic         flush_desc_recv_o;
    logic [2:0]   inflight_o;
`ifdef AXI_LLC_EVICT_PERF_EN
    logic [31:0]  evict_cnt_o, err_cnt_o;
`endif

    axi_llc_evict_tracker dut (
        .clk_i(clk), .rst_i(rst_i),
        .desc_i(desc_i), .desc_evict_i(desc_evict_i), .desc_flush_i(desc_flush_i),
        .desc_addr_i(desc_addr_i), .desc_len_i(desc_len_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_o(desc_o), .desc_err_o(desc_err_o),
        .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i),
        .rd_req_valid_o(rd_req_valid_o), .rd_req_ready_i(rd_req_ready_i),
        .rd_req_beat_o(rd_req_beat_o),
        .rd_data_i(rd_data_i), .rd_data_valid_i(rd_data_valid_i), .rd_data_ready_o(rd_data_ready_o),
        .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_id_o(aw_id_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .flush_desc_recv_o(flush_desc_recv_o),
`ifdef AXI_LLC_EVICT_PERF_EN
        .evict_cnt_o(evict_cnt_o), .err_cnt_o(err_cnt_o),
`endif
        .inflight_o(inflight_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       stall_en = 1'b0;
    logic       hold_b = 1'b0;
    logic [1:0] b_resp_cfg = 2'b00;

    // Monitor state (written only by the negedge monitor)
    logic f_rdreq = 1'b0, f_rddata = 1'b0, f_wlast = 1'b0, f_b = 1'b0;
    int aw_cnt = 0, w_cnt = 0, wlast_cnt = 0, rdreq_cnt = 0, b_cnt = 0, ret_cnt = 0;
    int w_data_bad = 0, wlast_bad = 0, w_before_aw = 0, aw_id_bad = 0, strb_bad = 0;
    int dv_cycles = 0, flush_cycles = 0, burst_beat = 0, burst_idx = 0, w_exp_seq = 0;
    logic [63:0]  aw_addr_arr [64];
    logic [7:0]   aw_len_arr  [64];
    logic [127:0] ret_desc    [64];
    logic         ret_err     [64];

    // Read-port responder state (written only by the posedge driver)
    int rd_seq = 0;
    int pend_b = 0;
    int rd_q[$];
    int dummy;

    function automatic logic [63:0] data_of(input int seq);
        return 64'h5A5A_0000_0000_0000 | 64'(seq);
    endfunction

    always @(negedge clk) begin
        if (rst_i) begin
            f_rdreq = 1'b0; f_rddata = 1'b0; f_wlast = 1'b0; f_b = 1'b0;
            burst_beat = 0;
            burst_idx = aw_cnt;
            w_exp_seq = rd_seq;
        end else begin
            f_rdreq  = rd_req_valid_o && rd_req_ready_i;
            f_rddata = w_valid_o && w_ready_i;
            f_wlast  = f_rddata && w_last_o;
            f_b      = b_valid_i && b_ready_o;
            if (aw_valid_o && aw_ready_i) begin
                aw_addr_arr[aw_cnt[5:0]] = aw_addr_o;
                aw_len_arr[aw_cnt[5:0]]  = aw_len_o;
                if (aw_id_o !== 4'd0) aw_id_bad++;
                aw_cnt++;
            end
            if (f_rdreq) rdreq_cnt++;
            if (f_rddata) begin
                w_cnt++;
                if (w_data_o !== data_of(w_exp_seq)) w_data_bad++;
                if (w_strb_o !== 8'hFF) strb_bad++;
                w_exp_seq++;
                if (burst_idx >= aw_cnt) w_before_aw++;
                else if (w_last_o !== (burst_beat == int'(aw_len_arr[burst_idx[5:0]]))) wlast_bad++;
                if (w_last_o) begin
                    wlast_cnt++;
                    burst_beat = 0;
                    burst_idx++;
                end else begin
                    burst_beat++;
                end
            end
            if (f_b) b_cnt++;
            if (desc_valid_o) dv_cycles++;
            if (desc_valid_o && desc_ready_i) begin
                ret_desc[ret_cnt[5:0]] = desc_o;
                ret_err[ret_cnt[5:0]]  = desc_err_o;
                ret_cnt++;
            end
            if (flush_desc_recv_o) flush_cycles++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_i) begin
            rd_q.delete();
            pend_b = 0;
        end else begin
            if (f_rddata && rd_q.size() > 0) dummy = rd_q.pop_front();
            if (f_rdreq) begin
                rd_q.push_back(rd_seq);
                rd_seq++;
            end
            if (f_wlast) pend_b++;
            if (f_b && pend_b > 0) pend_b--;
        end
        rd_req_ready_i  = !rst_i && (!stall_en || $urandom_range(0, 1) == 1);
        rd_data_valid_i = !rst_i && rd_q.size() > 0 && (!stall_en || $urandom_range(0, 1) == 1);
        rd_data_i       = rd_q.size() > 0 ? data_of(rd_q[0]) : 64'd0;
        w_ready_i       = !stall_en || $urandom_range(0, 1) == 1;
        b_valid_i       = !rst_i && pend_b > 0 && !hold_b;
        b_resp_i        = b_resp_cfg;
    end

    task automatic send_desc(input logic [127:0] p, input logic ev, input logic fl,
                             input logic [63:0] a, input logic [7:0] l);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        desc_i = p; desc_evict_i = ev; desc_flush_i = fl; desc_addr_i = a; desc_len_i = l;
        desc_valid_i = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (desc_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_desc_timeout: desc_ready_o stuck at %0b, required 1", desc_ready_o);
        end
        @(posedge clk); #1;
        desc_valid_i = 1'b0;
    endtask

    task automatic wait_ret(input int target);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (ret_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL retire_timeout: retired %0d, required %0d", ret_cnt, target);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({desc_ready_o, desc_valid_o, aw_valid_o, w_valid_o, rd_req_valid_o, b_ready_o,
             flush_desc_recv_o, rd_data_ready_o, w_last_o} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl_outputs: ready=%0b dv=%0b aw=%0b w=%0b rq=%0b b=%0b fl=%0b, required all 0",
                     desc_ready_o, desc_valid_o, aw_valid_o, w_valid_o, rd_req_valid_o, b_ready_o, flush_desc_recv_o);
        end
        checks++;
        if (inflight_o !== 3'd0 || w_strb_o !== 8'd0 || desc_o !== 128'd0) begin
            errors++;
            $display("FAIL reset_data_outputs: inflight=%0d strb=%h desc=%h, required 0", inflight_o, w_strb_o, desc_o);
        end
`ifdef AXI_LLC_EVICT_PERF_EN
        checks++;
        if (evict_cnt_o !== 32'd0 || err_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: evict=%0d err=%0d, required 0", evict_cnt_o, err_cnt_o);
        end
`endif
        @(posedge clk); #1;
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (desc_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: desc_ready_o=%0b, required 1", desc_ready_o);
        end
    endtask

    task automatic test_single_evict;
        int aw0, w0, wl0, r0;
        aw0 = aw_cnt; w0 = w_cnt; wl0 = wlast_cnt; r0 = ret_cnt;
        send_desc(128'hA1, 1'b1, 1'b0, 64'h1000, 8'd3);
        wait_ret(r0 + 1);
        checks++;
        if (aw_cnt - aw0 !== 1 || aw_addr_arr[aw0[5:0]] !== 64'h1000 || aw_len_arr[aw0[5:0]] !== 8'd3) begin
            errors++;
            $display("FAIL single_aw: count=%0d addr=%h len=%0d, required 1/1000/3",
                     aw_cnt - aw0, aw_addr_arr[aw0[5:0]], aw_len_arr[aw0[5:0]]);
        end
        checks++;
        if (w_cnt - w0 !== 4 || wlast_cnt - wl0 !== 1 || wlast_bad !== 0) begin
            errors++;
            $display("FAIL single_w_beats: beats=%0d lasts=%0d last_misplaced=%0d, required 4/1/0",
                     w_cnt - w0, wlast_cnt - wl0, wlast_bad);
        end
        checks++;
        if (w_data_bad !== 0 || aw_id_bad !== 0 || strb_bad !== 0) begin
            errors++;
            $display("FAIL single_w_data: data_bad=%0d id_bad=%0d strb_bad=%0d, required 0", w_data_bad, aw_id_bad, strb_bad);
        end
        checks++;
        if (ret_desc[r0[5:0]] !== 128'hA1 || ret_err[r0[5:0]] !== 1'b0) begin
            errors++;
            $display("FAIL single_retire: desc=%h err=%0b, required a1/0", ret_desc[r0[5:0]], ret_err[r0[5:0]]);
        end
        checks++;
        if (inflight_o !== 3'd0) begin
            errors++;
            $display("FAIL single_inflight: %0d, required 0", inflight_o);
        end
    endtask

    task automatic test_back_to_back;
        int aw0, w0, rq0, r0;
        aw0 = aw_cnt; w0 = w_cnt; rq0 = rdreq_cnt; r0 = ret_cnt;
        aw_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_desc(128'hB0 + 128'(k), 1'b1, 1'b0, 64'h2000 + 64'(k * 256), 8'd1);
        end
        @(negedge clk);
        checks++;
        if (desc_ready_o !== 1'b0 || inflight_o !== 3'd4) begin
            errors++;
            $display("FAIL b2b_full: ready=%0b inflight=%0d, required 0/4", desc_ready_o, inflight_o);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (w_cnt - w0 !== 0 || rdreq_cnt - rq0 !== 0 || aw_cnt - aw0 !== 0) begin
            errors++;
            $display("FAIL b2b_no_w_before_aw: w=%0d rdreq=%0d aw=%0d, required 0", w_cnt - w0, rdreq_cnt - rq0, aw_cnt - aw0);
        end
        aw_ready_i = 1'b1;
        wait_ret(r0 + 4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ret_desc[6'(r0 + k)] !== 128'hB0 + 128'(k) || aw_addr_arr[6'(aw0 + k)] !== 64'h2000 + 64'(k * 256)) begin
                errors++;
                $display("FAIL b2b_order_%0d: desc=%h aw_addr=%h, required %h/%h", k, ret_desc[6'(r0 + k)],
                         aw_addr_arr[6'(aw0 + k)], 128'hB0 + 128'(k), 64'h2000 + 64'(k * 256));
            end
        end
        checks++;
        if (w_cnt - w0 !== 8 || w_before_aw !== 0 || w_data_bad !== 0) begin
            errors++;
            $display("FAIL b2b_w: beats=%0d w_before_aw=%0d data_bad=%0d, required 8/0/0", w_cnt - w0, w_before_aw, w_data_bad);
        end
    endtask

    task automatic test_nonevict_behind;
        int aw0, w0, r0;
        aw0 = aw_cnt; w0 = w_cnt; r0 = ret_cnt;
        hold_b = 1'b1;
        send_desc(128'hC1, 1'b1, 1'b0, 64'h3000, 8'd0);
        send_desc(128'hC2, 1'b0, 1'b0, 64'h3100, 8'd5);
        repeat (20) @(negedge clk);
        checks++;
        if (ret_cnt - r0 !== 0 || inflight_o !== 3'd2) begin
            errors++;
            $display("FAIL nonevict_wait_b: retired=%0d inflight=%0d, required 0/2", ret_cnt - r0, inflight_o);
        end
        hold_b = 1'b0;
        wait_ret(r0 + 2);
        checks++;
        if (ret_desc[r0[5:0]] !== 128'hC1 || ret_desc[6'(r0 + 1)] !== 128'hC2) begin
            errors++;
            $display("FAIL nonevict_order: first=%h second=%h, required c1/c2", ret_desc[r0[5:0]], ret_desc[6'(r0 + 1)]);
        end
        checks++;
        if (aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1 || wlast_bad !== 0) begin
            errors++;
            $display("FAIL nonevict_no_traffic: aw=%0d w=%0d last_bad=%0d, required 1/1/0", aw_cnt - aw0, w_cnt - w0, wlast_bad);
        end
    endtask

    task automatic test_flush;
        int f0, dv0, r0;
        bit ok;
        f0 = flush_cycles; dv0 = dv_cycles; r0 = ret_cnt;
        ok = 1'b0;
        b_resp_cfg = 2'b10;
        send_desc(128'hD1, 1'b1, 1'b1, 64'h4000, 8'd1);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (flush_cycles > f0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || flush_cycles - f0 !== 1) begin
            errors++;
            $display("FAIL flush_pulse: pulse_cycles=%0d, required 1", flush_cycles - f0);
        end
        checks++;
        if (dv_cycles - dv0 !== 0 || ret_cnt - r0 !== 0 || inflight_o !== 3'd0) begin
            errors++;
            $display("FAIL flush_no_forward: dv_cycles=%0d retired=%0d inflight=%0d, required 0/0/0",
                     dv_cycles - dv0, ret_cnt - r0, inflight_o);
        end
`ifdef AXI_LLC_EVICT_PERF_EN
        checks++;
        if (err_cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL flush_err_cnt: %0d, required 1", err_cnt_o);
        end
`endif
        b_resp_cfg = 2'b11;
        send_desc(128'hD2, 1'b1, 1'b0, 64'h4100, 8'd0);
        wait_ret(r0 + 1);
        b_resp_cfg = 2'b00;
        checks++;
        if (ret_desc[r0[5:0]] !== 128'hD2 || ret_err[r0[5:0]] !== 1'b1) begin
            errors++;
            $display("FAIL err_retire: desc=%h err=%0b, required d2/1", ret_desc[r0[5:0]], ret_err[r0[5:0]]);
        end
`ifdef AXI_LLC_EVICT_PERF_EN
        checks++;
        if (err_cnt_o !== 32'd2 || evict_cnt_o !== 32'(aw_cnt)) begin
            errors++;
            $display("FAIL perf_counts: err=%0d evict=%0d, required 2/%0d", err_cnt_o, evict_cnt_o, aw_cnt);
        end
`endif
    endtask

    task automatic test_stall;
        int rq0, w0, wl0, r0;
        rq0 = rdreq_cnt; w0 = w_cnt; wl0 = wlast_cnt; r0 = ret_cnt;
        stall_en = 1'b1;
        send_desc(128'hE1, 1'b1, 1'b0, 64'h5000, 8'd7);
        wait_ret(r0 + 1);
        stall_en = 1'b0;
        checks++;
        if (rdreq_cnt - rq0 !== 8 || w_cnt - w0 !== 8 || wlast_cnt - wl0 !== 1) begin
            errors++;
            $display("FAIL stall_counts: rdreq=%0d w=%0d last=%0d, required 8/8/1", rdreq_cnt - rq0, w_cnt - w0, wlast_cnt - wl0);
        end
        checks++;
        if (w_data_bad !== 0 || wlast_bad !== 0 || ret_desc[r0[5:0]] !== 128'hE1) begin
            errors++;
            $display("FAIL stall_data: data_bad=%0d last_bad=%0d desc=%h, required 0/0/e1", w_data_bad, wlast_bad, ret_desc[r0[5:0]]);
        end
    endtask

    task automatic test_reset_mid;
        int w0, r0;
        bit ok;
        w0 = w_cnt;
        ok = 1'b0;
        stall_en = 1'b1;
        send_desc(128'hF1, 1'b1, 1'b0, 64'h6000, 8'd7);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (w_cnt - w0 >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid_progress: beats=%0d, required >=2", w_cnt - w0);
        end
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({desc_ready_o, desc_valid_o, aw_valid_o, w_valid_o, rd_req_valid_o, b_ready_o,
             flush_desc_recv_o, rd_data_ready_o, w_last_o} !== 9'd0 || inflight_o !== 3'd0 || w_data_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: ready=%0b w=%0b rq=%0b inflight=%0d wdata=%h, required all 0",
                     desc_ready_o, w_valid_o, rd_req_valid_o, inflight_o, w_data_o);
        end
        stall_en = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        r0 = ret_cnt;
        send_desc(128'hF2, 1'b0, 1'b0, 64'h0, 8'd0);
        wait_ret(r0 + 1);
        checks++;
        if (ret_desc[r0[5:0]] !== 128'hF2 || inflight_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_reaccept: desc=%h inflight=%0d, required f2/0", ret_desc[r0[5:0]], inflight_o);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        desc_i = '0; desc_evict_i = 1'b0; desc_flush_i = 1'b0; desc_addr_i = '0; desc_len_i = '0;
        desc_valid_i = 1'b0; desc_ready_i = 1'b1; aw_ready_i = 1'b1;
        test_reset();
        test_single_evict();
        test_back_to_back();
        test_nonevict_behind();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
